apb_decode_n: RTL

//  Parametrised 1-to-N APB3 address decoder/bridge, the successor of the fixed two-target decoder.

---
 rtl/apb_decode_n_pkg.sv | 33 +++
 rtl/apb_addr_match.sv | 27 ++
 rtl/apb_decode_n.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_decode_n_pkg.sv
// Shared types, default address map and width helper for the 1-to-N APB decoder.
package apb_decode_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apbDecState_t;

    localparam int unsigned DEF_NUM_TGT = 4;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;

    typedef logic [DEF_ADDR_W-1:0] apbAddrSt;
    typedef logic [DEF_DATA_W-1:0] apbDataSt;

    localparam apbAddrSt DEF_ADDR_MASK = 32'h0fff_ffff;

    // Reference map: t0/t1/t2 are 1 MiB regions, t3 is a 512 KiB alias inside t2.
    localparam logic [DEF_NUM_TGT*DEF_ADDR_W-1:0] DEF_TGT_BASE = {
        32'h0020_0000, 32'h0020_0000, 32'h0010_0000, 32'h0000_0000
    };
    localparam logic [DEF_NUM_TGT*DEF_ADDR_W-1:0] DEF_TGT_MASK = {
        32'h0007_ffff, 32'h000f_ffff, 32'h000f_ffff, 32'h000f_ffff
    };

    // clog2 that never collapses to a zero-width vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_match.sv
// Combinational priority address matcher; the lowest-index matching target wins.
module apb_addr_match #(
    parameter int unsigned NUM_TGT = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [ADDR_W-1:0]         a,
    input  logic [NUM_TGT*ADDR_W-1:0] tgt_base,
    input  logic [NUM_TGT*ADDR_W-1:0] tgt_mask,
    output logic                      hit,
    output logic [IDX_W-1:0]          idx
);

    // Scan from the top down so the last (lowest) matching index overrides.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if ((a & ~tgt_mask[i*ADDR_W +: ADDR_W]) ==
                (tgt_base[i*ADDR_W +: ADDR_W] & ~tgt_mask[i*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_decode_n.sv
// 1-to-N APB3 decoder/bridge with registered request/response, error slave and timeout.
module apb_decode_n
    import apb_decode_n_pkg::*;
#(
    parameter int unsigned               NUM_TGT     = 4,
    parameter int unsigned               ADDR_W      = 32,
    parameter int unsigned               DATA_W      = 32,
    parameter logic [ADDR_W-1:0]         ADDR_MASK   = ADDR_W'(32'h0fff_ffff),
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE    = '0,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK    = '0,
    parameter int unsigned               TIMEOUT_CYC = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [ADDR_W-1:0]         s_paddr,
    input  logic [DATA_W-1:0]         s_pwdata,
    input  logic [DATA_W/8-1:0]       s_pstrb,
    output logic                      s_pready,
    output logic [DATA_W-1:0]         s_prdata,
    output logic                      s_pslverr,
    output logic [NUM_TGT-1:0]        m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [DATA_W-1:0]         m_pwdata,
    output logic [DATA_W/8-1:0]       m_pstrb,
    input  logic [NUM_TGT-1:0]        m_pready,
    input  logic [NUM_TGT*DATA_W-1:0] m_prdata,
    input  logic [NUM_TGT-1:0]        m_pslverr,
    output logic                      err_decode,
    output logic                      err_timeout,
    output logic                      busy
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned IDX_W    = clog2_min1(NUM_TGT);
    localparam int unsigned CNT_W    = clog2_min1(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    apbDecState_t        state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_TGT-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pready_q, pready_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pslverr_q, pslverr_d;
    logic                err_dec_q, err_dec_d;
    logic                err_to_q, err_to_d;
    logic                busy_q, busy_d;

    logic [ADDR_W-1:0]   addr_masked;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [DATA_W-1:0]   tgt_rdata;
    logic                unused_penable;

    // The bridge starts on psel alone; penable carries no extra information here.
    assign unused_penable = s_penable;

    assign addr_masked = s_paddr & ADDR_MASK;
    assign tgt_rdata   = m_prdata[idx_q*DATA_W +: DATA_W];

    apb_addr_match #(
        .NUM_TGT (NUM_TGT),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_match (
        .a        (addr_masked),
        .tgt_base (TGT_BASE),
        .tgt_mask (TGT_MASK),
        .hit      (hit),
        .idx      (hit_idx)
    );

    // Next-state and registered-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        psel_d    = '0;
        penable_d = 1'b0;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        err_dec_d = 1'b0;
        err_to_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_psel) begin
                    addr_d   = addr_masked;
                    pwrite_d = s_pwrite;
                    pwdata_d = s_pwdata;
                    pstrb_d  = s_pstrb;
                    idx_d    = hit_idx;
                    if (hit) begin
                        state_d = ST_SETUP;
                        psel_d  = NUM_TGT'(1) << hit_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d   = ST_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        err_dec_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                psel_d    = NUM_TGT'(1) << idx_q;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (m_pready[idx_q]) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    prdata_d  = pwrite_q ? '0 : tgt_rdata;
                    pslverr_d = m_pslverr[idx_q];
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
                    state_d   = ST_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    err_to_d  = 1'b1;
                end else begin
                    psel_d    = NUM_TGT'(1) << idx_q;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            err_dec_q <= 1'b0;
            err_to_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            err_dec_q <= err_dec_d;
            err_to_q  <= err_to_d;
            busy_q    <= busy_d;
        end
    end

    assign s_pready    = pready_q;
    assign s_prdata    = prdata_q;
    assign s_pslverr   = pslverr_q;
    assign m_psel      = psel_q;
    assign m_penable   = penable_q;
    assign m_pwrite    = pwrite_q;
    assign m_paddr     = addr_q;
    assign m_pwdata    = pwdata_q;
    assign m_pstrb     = pstrb_q;
    assign err_decode  = err_dec_q;
    assign err_timeout = err_to_q;
    assign busy        = busy_q;

endmodule
